// File: rtl/prga_prog_pkg.sv
// Shared types and width helpers for the PRGA programming-chain streamer.
package prga_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    function automatic int unsigned groups_per_word(input int unsigned word_w,
                                                    input int unsigned num_chains);
        return word_w / num_chains;
    endfunction

    // Width of a group index; never collapses to zero bits.
    function automatic int unsigned grp_idx_w(input int unsigned groups);
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_val (bit_cnt, stall, reset timer).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/prga_prog_serializer.sv
// Single-word buffer that shifts out NUM_CHAINS bits per cycle, LSB group first.
module prga_prog_serializer
    import prga_prog_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = 1,
    parameter int unsigned WORD_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [WORD_W-1:0]     data_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    output logic [NUM_CHAINS-1:0] din_o,
    output logic                  valid_nxt_c_o,
    output logic                  last_nxt_c_o
);

    localparam int unsigned GROUPS = groups_per_word(WORD_W, NUM_CHAINS);
    localparam int unsigned REM_W  = grp_idx_w(GROUPS);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              valid_q, valid_d;

    // rem counts groups still queued behind the one currently presented.
    always_comb begin
        shreg_d = shreg_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        if (valid_q) begin
            shreg_d = shreg_q >> NUM_CHAINS;
            if (rem_q == '0) begin
                valid_d = 1'b0;
            end else begin
                rem_d = rem_q - REM_W'(1);
            end
        end
        if (load_i) begin
            shreg_d = data_i;
            rem_d   = REM_W'(GROUPS - 1);
            valid_d = 1'b1;
        end
        if (flush_i) begin
            shreg_d = '0;
            rem_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o       = valid_q;
    assign din_o         = shreg_q[NUM_CHAINS-1:0];
    assign valid_nxt_c_o = valid_d;
    assign last_nxt_c_o  = (rem_d == '0);

endmodule

// File: rtl/prga_prog_streamer.sv
// Streams a word-wide bitstream into NUM_CHAINS parallel PRGA programming scan chains.
module prga_prog_streamer
    import prga_prog_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = 1,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned CHAIN_LEN  = 4096,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned STALL_MAX  = 1024
) (
    input  logic                          prog_clk,
    input  logic                          prog_rst_n,
    input  logic                          start,
    input  logic                          s_valid,
    input  logic [WORD_W-1:0]             s_data,
    output logic                          s_ready,
    output logic                          prog_rst,
    output logic                          prog_we,
    output logic [NUM_CHAINS-1:0]         prog_din,
    output logic                          prog_done,
    output logic                          busy,
    output logic                          err,
    output logic [cnt_w(CHAIN_LEN)-1:0]   bit_cnt
);

    localparam int unsigned CNT_W   = cnt_w(CHAIN_LEN);
    localparam int unsigned STALL_W = cnt_w(STALL_MAX);
    localparam int unsigned RSTC_W  = cnt_w(RST_CYCLES);

    state_e             state_q, state_d;
    logic [RSTC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               s_ready_q, s_ready_d;
    logic               prog_rst_q, prog_rst_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic accept;
    logic flush;
    logic ser_valid;
    logic ser_valid_nxt;
    logic ser_last_nxt;

    assign accept = s_valid && s_ready_q;
    assign flush  = (state_d != ST_LOAD);

    prga_prog_serializer #(
        .NUM_CHAINS (NUM_CHAINS),
        .WORD_W     (WORD_W)
    ) u_ser (
        .clk           (prog_clk),
        .rst_n         (prog_rst_n),
        .load_i        (accept),
        .data_i        (s_data),
        .flush_i       (flush),
        .valid_o       (ser_valid),
        .din_o         (prog_din),
        .valid_nxt_c_o (ser_valid_nxt),
        .last_nxt_c_o  (ser_last_nxt)
    );

    // Next-state and counter logic; a valid serializer word means a shift happens this cycle.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        bit_cnt_d = bit_cnt_q;
        stall_d   = stall_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_RST;
                    rst_cnt_d = '0;
                    bit_cnt_d = '0;
                    stall_d   = '0;
                end
            end
            ST_RST: begin
                if (rst_cnt_q == RSTC_W'(RST_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    rst_cnt_d = rst_cnt_q + RSTC_W'(1);
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    stall_d = '0;
                end else if (!ser_valid && !s_valid) begin
                    stall_d = stall_q + STALL_W'(1);
                    if (stall_d == STALL_W'(STALL_MAX)) begin
                        state_d = ST_ERROR;
                    end
                end
                if (ser_valid) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is precomputed so it reflects the buffer occupancy of the cycle it is presented in.
    always_comb begin
        prog_rst_d = (state_d == ST_RST);
        busy_d     = (state_d == ST_RST) || (state_d == ST_LOAD);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERROR);
        s_ready_d  = (state_d == ST_LOAD) &&
                     (!ser_valid_nxt ||
                      (ser_last_nxt && ((32'(bit_cnt_d) + 32'd1) < CHAIN_LEN)));
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q    <= ST_IDLE;
            rst_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            stall_q    <= '0;
            s_ready_q  <= 1'b0;
            prog_rst_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stall_q    <= stall_d;
            s_ready_q  <= s_ready_d;
            prog_rst_q <= prog_rst_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign prog_rst  = prog_rst_q;
    assign prog_we   = ser_valid;
    assign prog_done = done_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign bit_cnt   = bit_cnt_q;

endmodule
